// File: rtl/sample_ram.sv
// Shared CPU/ADC sample memory: one CPU port plus NUM_CH ADC channels. Each channel
// streams into its own ring region through a one-entry holding register.
module sample_ram #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DEPTH         = 4096,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned REGION_BITS   = 10,
  parameter int unsigned CH_BASE       = 2048
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wEn,
  input  logic [ADDRESS_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]         dataIn,
  output logic [DATA_WIDTH-1:0]         dataOut,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  ch_data,
  output logic [NUM_CH-1:0]             ch_ready,
  output logic [NUM_CH*REGION_BITS-1:0] ch_wptr,
  output logic [NUM_CH-1:0]             ch_wrap,
  input  logic                          wrap_clr
);

  localparam int unsigned IdxW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned RegionWords = 1 << REGION_BITS;

  logic [DATA_WIDTH-1:0]                  r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]                  r_dout;
  logic [NUM_CH-1:0]                      r_full;
  logic [NUM_CH-1:0]                      r_wrap;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]      r_hold;
  logic [NUM_CH-1:0][REGION_BITS-1:0]     r_wptr;
  logic [IdxW-1:0]                        r_last;

  logic                     w_gnt_any;
  logic [IdxW-1:0]          w_gnt_idx;
  logic [IdxW-1:0]          w_cand;
  logic [NUM_CH-1:0]        w_wrap_set;
  logic                     w_we;
  logic [ADDRESS_WIDTH-1:0] w_waddr;
  logic [ADDRESS_WIDTH-1:0] w_ch_addr;
  logic [DATA_WIDTH-1:0]    w_wdata;

  // Round-robin search starting one past the last granted channel; CPU writes block all grants.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    if (!wEn) begin
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
        w_cand = IdxW'((32'(r_last) + i) % NUM_CH);
        if (!w_gnt_any && r_full[w_cand]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end
  end

  always_comb begin
    w_ch_addr  = ADDRESS_WIDTH'(CH_BASE + 32'(w_gnt_idx) * RegionWords
                                + 32'(r_wptr[w_gnt_idx]));
    w_we       = !reset && (wEn || w_gnt_any);
    w_waddr    = wEn ? addr : w_ch_addr;
    w_wdata    = wEn ? dataIn : r_hold[w_gnt_idx];
    w_wrap_set = '0;
    if (w_gnt_any && (&r_wptr[w_gnt_idx])) begin
      w_wrap_set[w_gnt_idx] = 1'b1;
    end
  end

  // Single write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (ch_valid[c] && !r_full[c]) begin
        r_hold[c] <= ch_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
      r_full <= '0;
      r_wptr <= '0;
      r_wrap <= '0;
      r_last <= IdxW'(NUM_CH - 1);
    end else begin
      r_dout <= r_mem[addr];
      // A granted channel is full, so it never captures in the same cycle.
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (ch_valid[c] && !r_full[c]) begin
          r_full[c] <= 1'b1;
        end
      end
      if (w_gnt_any) begin
        r_full[w_gnt_idx] <= 1'b0;
        r_wptr[w_gnt_idx] <= r_wptr[w_gnt_idx] + REGION_BITS'(1);
        r_last            <= w_gnt_idx;
      end
      r_wrap <= (r_wrap & ~{NUM_CH{wrap_clr}}) | w_wrap_set;
    end
  end

  assign dataOut  = r_dout;
  assign ch_ready = ~r_full;
  assign ch_wptr  = r_wptr;
  assign ch_wrap  = r_wrap;

endmodule

// File: tb/tb_sample_ram.sv
// Bench for sample_ram: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a rule-level memory/channel model.
module tb_sample_ram;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;
  localparam int NCH   = 2;
  localparam int RB    = 10;
  localparam int BASE  = 2048;

  logic              clk = 1'b0;
  logic              reset;
  logic              wEn;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     dataIn;
  logic [DW-1:0]     dataOut;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*RB-1:0] ch_wptr;
  logic [NCH-1:0]    ch_wrap;
  logic              wrap_clr;

  always #5 clk = ~clk;

  sample_ram #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .DEPTH        (DEPTH),
    .NUM_CH       (NCH),
    .REGION_BITS  (RB),
    .CH_BASE      (BASE)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .wEn     (wEn),
    .addr    (addr),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .ch_valid(ch_valid),
    .ch_data (ch_data),
    .ch_ready(ch_ready),
    .ch_wptr (ch_wptr),
    .ch_wrap (ch_wrap),
    .wrap_clr(wrap_clr)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_full  [NCH];
  logic [DW-1:0] m_hold  [NCH];
  int            m_wptr  [NCH];
  bit            m_wrap  [NCH];
  int            m_last;
  logic [DW-1:0] m_dout;
  bit            m_dout_known;
  bit            m_live = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int g;
    if (reset) begin
      m_live       = 1'b1;
      m_dout       = '0;
      m_dout_known = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        m_full[c] = 1'b0;
        m_wptr[c] = 0;
        m_wrap[c] = 1'b0;
      end
      m_last = NCH - 1;
      return;
    end
    if (!m_live) return;
    m_dout_known = m_known[addr];
    m_dout       = m_mem[addr];
    g = -1;
    if (!wEn) begin
      for (int i = 1; i <= NCH; i++) begin
        int k;
        k = (m_last + i) % NCH;
        if (g < 0 && m_full[k]) g = k;
      end
    end
    if (wEn) begin
      m_mem[addr]   = dataIn;
      m_known[addr] = 1'b1;
    end else if (g >= 0) begin
      int a;
      a = BASE + g * (1 << RB) + m_wptr[g];
      m_mem[a]   = m_hold[g];
      m_known[a] = 1'b1;
    end
    for (int c = 0; c < NCH; c++) begin
      if (ch_valid[c] && !m_full[c]) begin
        m_full[c] = 1'b1;
        m_hold[c] = ch_data[c*DW +: DW];
      end
      if (wrap_clr) m_wrap[c] = 1'b0;
    end
    if (g >= 0) begin
      m_full[g] = 1'b0;
      if (m_wptr[g] == (1 << RB) - 1) m_wrap[g] = 1'b1;
      m_wptr[g] = (m_wptr[g] + 1) % (1 << RB);
      m_last    = g;
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0]    e_ready;
    logic [NCH-1:0]    e_wrap;
    logic [NCH*RB-1:0] e_wptr;
    if (!m_live) return;
    for (int c = 0; c < NCH; c++) begin
      e_ready[c]         = !m_full[c];
      e_wrap[c]          = m_wrap[c];
      e_wptr[c*RB +: RB] = RB'(m_wptr[c]);
    end
    if (m_dout_known) check("model_dataOut", dataOut, m_dout);
    check("model_ch_ready", ch_ready, e_ready);
    check("model_ch_wptr", ch_wptr, e_wptr);
    check("model_ch_wrap", ch_wrap, e_wrap);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_ch(input int c, input logic [DW-1:0] d);
    ch_data[c*DW +: DW] = d;
  endtask

  initial begin
    reset    = 1'b1;
    wEn      = 1'b0;
    addr     = '0;
    dataIn   = '0;
    ch_valid = '0;
    ch_data  = '0;
    wrap_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_dataOut", dataOut, 32'h0);
    check("reset_ready", ch_ready, 2'b11);
    check("reset_wptr", ch_wptr, 20'h0);
    check("reset_wrap", ch_wrap, 2'b00);

    // Simultaneous pair after reset: ch0 first, then ch1
    addr     = 12'd2048;
    set_ch(0, 32'hA5A5_0001);
    set_ch(1, 32'hB000_0001);
    ch_valid = 2'b11;
    tick();
    check("pair_captured_ready", ch_ready, 2'b00);
    ch_valid = 2'b00;
    tick();
    check("pair_ch0_first_wptr", ch_wptr, 20'h00001);
    check("pair_ch0_first_ready", ch_ready, 2'b01);
    tick();
    check("pair_ch1_second_wptr", ch_wptr, 20'h00401);
    check("ch0_sample_readback", dataOut, 32'hA5A5_0001);

    // After a lone ch0 grant, the next simultaneous pair goes to ch1 first
    set_ch(0, 32'hA5A5_0002);
    ch_valid = 2'b01;
    tick();
    ch_valid = 2'b00;
    tick();
    set_ch(0, 32'hA5A5_0003);
    set_ch(1, 32'hB000_0002);
    ch_valid = 2'b11;
    tick();
    ch_valid = 2'b00;
    tick();
    check("rr_ch1_first_wptr", ch_wptr, 20'h00802);
    tick();
    check("rr_ch0_second_wptr", ch_wptr, 20'h00803);

    // CPU writes hold off a pending ch1 sample for five cycles
    wEn      = 1'b1;
    addr     = 12'd5;
    dataIn   = $urandom;
    set_ch(1, 32'hB000_0003);
    ch_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      ch_valid = 2'b00;
      check("hold_ready1_low", ch_ready[1], 1'b0);
      check("hold_wptr1", ch_wptr[2*RB-1:RB], 10'd2);
    end
    wEn = 1'b0;
    tick();
    check("release_wptr1", ch_wptr[2*RB-1:RB], 10'd3);
    check("release_ready1", ch_ready[1], 1'b1);
    addr = 12'd3074;
    tick();
    check("held_sample_readback", dataOut, 32'hB000_0003);

    // Read-before-write on a CPU write to the address being read
    wEn    = 1'b1;
    addr   = 12'd100;
    dataIn = 32'hDEAD_0000;
    tick();
    wEn = 1'b0;
    tick();
    wEn    = 1'b1;
    dataIn = 32'h0000_1234;
    tick();
    check("rbw_old_value", dataOut, 32'hDEAD_0000);
    wEn = 1'b0;
    tick();
    check("rbw_new_value", dataOut, 32'h0000_1234);

    // Reset with ch1 holding a sample: the sample is dropped, memory untouched
    wEn    = 1'b1;
    addr   = 12'd3075;
    dataIn = 32'h5555_5555;
    tick();
    wEn      = 1'b0;
    set_ch(1, 32'hB000_0004);
    ch_valid = 2'b10;
    tick();
    ch_valid = 2'b00;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_wptr", ch_wptr, 20'h0);
    check("midreset_wrap", ch_wrap, 2'b00);
    check("midreset_dataOut", dataOut, 32'h0);
    check("midreset_ready", ch_ready, 2'b11);
    tick();
    check("midreset_no_write", dataOut, 32'h5555_5555);
    addr = 12'd3072;
    tick();
    check("midreset_mem_intact", dataOut, 32'hB000_0001);

    // Fill ch0's ring; wrap_clr coincides with the wrapping write
    addr = 12'd2048;
    for (int k = 1; k <= 1024; k++) begin
      set_ch(0, 32'hC000_0000 | 32'(k));
      ch_valid = 2'b01;
      tick();
      ch_valid = 2'b00;
      wrap_clr = (k == 1024);
      tick();
      wrap_clr = 1'b0;
    end
    check("wrap_wptr0", ch_wptr[RB-1:0], 10'd0);
    check("wrap_set_wins", ch_wrap[0], 1'b1);
    wrap_clr = 1'b1;
    tick();
    wrap_clr = 1'b0;
    check("wrap_cleared", ch_wrap, 2'b00);
    set_ch(0, 32'hC000_0401);
    ch_valid = 2'b01;
    tick();
    ch_valid = 2'b00;
    tick();
    check("wrap_old_word", dataOut, 32'hC000_0001);
    tick();
    check("wrap_sample1025_at_base", dataOut, 32'hC000_0401);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 499) == 0);
      wEn      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) addr = AW'(BASE + $urandom_range(0, NCH * (1 << RB) - 1));
      else addr = AW'($urandom);
      dataIn   = $urandom;
      ch_valid = NCH'($urandom);
      for (int c = 0; c < NCH; c++) set_ch(c, $urandom);
      wrap_clr = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
